// File: rtl/os_tile_sequencer_if.sv
// Host-to-sequencer bundle: tile command in, array/buffer controls out.
// Latency: none (wires only).
// Backpressure: start is only honoured while busy is low; no other flow control.
//
// master: host/command decoder side (drives start + cfg, observes status/controls)
// slave : sequencer side (receives start + cfg, drives status/controls)
interface os_tile_sequencer_if #(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 32
);
  localparam int RW = $clog2(ARRAY_N) + 1;
  localparam int CW = $clog2(ARRAY_M) + 1;

  // command
  logic                  start;
  logic [CNT_WIDTH-1:0]  cfg_k;
  logic [RW-1:0]         cfg_num_rows;
  logic [CW-1:0]         cfg_num_cols;
  logic [ADDR_WIDTH-1:0] cfg_a_base;
  logic [ADDR_WIDTH-1:0] cfg_w_base;
  logic [ADDR_WIDTH-1:0] cfg_o_base;

  // status
  logic                  busy;
  logic                  done;
  logic                  err;

  // systolic_system controls
  logic                  mode;
  logic                  a_buf_on;
  logic                  w_buf_on;
  logic [ADDR_WIDTH-1:0] a_base_addr;
  logic [ADDR_WIDTH-1:0] w_base_addr;
  logic [ADDR_WIDTH-1:0] o_base_addr;
  logic [RW-1:0]         a_num_rows;
  logic [CW-1:0]         w_num_cols;
  logic [2:0]            operation_signal_in;
  logic                  o_ag_o_on;

  modport master (
    output start, cfg_k, cfg_num_rows, cfg_num_cols, cfg_a_base, cfg_w_base, cfg_o_base,
    input  busy, done, err, mode, a_buf_on, w_buf_on, a_base_addr, w_base_addr,
           o_base_addr, a_num_rows, w_num_cols, operation_signal_in, o_ag_o_on
  );

  modport slave (
    input  start, cfg_k, cfg_num_rows, cfg_num_cols, cfg_a_base, cfg_w_base, cfg_o_base,
    output busy, done, err, mode, a_buf_on, w_buf_on, a_base_addr, w_base_addr,
           o_base_addr, a_num_rows, w_num_cols, operation_signal_in, o_ag_o_on
  );
endinterface

// File: rtl/os_tile_sequencer.sv
// Sequences one output-stationary tile on systolic_system: FLOW, SKEW, DRAIN, STORE, DONE.
// Latency: controls registered, first phase outputs one cycle after start is sampled.
// Backpressure: start accepted only in IDLE; start while busy is dropped silently.
//
// Ports: clk (rising edge), reset (async, active low), bus (os_tile_sequencer_if.slave):
//   start/cfg_* in; busy/done/err status and buffer/op/aggregation controls out.
module os_tile_sequencer #(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  os_tile_sequencer_if.slave  bus
);
  localparam int RW = $clog2(ARRAY_N) + 1;
  localparam int CW = $clog2(ARRAY_M) + 1;
  localparam logic [RW-1:0]        ROWS_MAX = RW'(ARRAY_N);
  localparam logic [CW-1:0]        COLS_MAX = CW'(ARRAY_M);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] N_EXT    = CNT_WIDTH'(ARRAY_N);

  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_FLOW  = 3'b100;
  localparam logic [2:0] OP_DRAIN = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_FLOW, S_SKEW, S_DRAIN, S_STORE, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;

  logic                  accept, reject;
  logic                  busy_nxt, flow_nxt, ag_nxt, done_nxt;
  logic [2:0]            op_nxt;

  logic                  busy_q, done_q, err_q, flow_q, ag_q;
  logic [2:0]            op_q;
  logic [RW-1:0]         rows_q;
  logic [CW-1:0]         cols_q;
  logic [ADDR_WIDTH-1:0] a_base_q, w_base_q, o_base_q;

  logic                  cfg_legal;
  logic [RW-1:0]         rows_sel;
  logic [CW-1:0]         cols_sel;
  logic [CNT_WIDTH-1:0]  rows_ext, cols_ext;
  logic [CNT_WIDTH-1:0]  skew_len, drain_len, store_len;

  assign cfg_legal = (bus.cfg_num_rows != '0) && (bus.cfg_num_rows <= ROWS_MAX) &&
                     (bus.cfg_num_cols != '0) && (bus.cfg_num_cols <= COLS_MAX);

  // In IDLE a K=0 start jumps straight into SKEW, so its length must come from
  // the live cfg inputs; afterwards the latched copies are used.
  assign rows_sel = (state == S_IDLE) ? bus.cfg_num_rows : rows_q;
  assign cols_sel = (state == S_IDLE) ? bus.cfg_num_cols : cols_q;

  // Phase lengths at full counter width so nothing wraps for any legal R/C.
  assign rows_ext  = {{(CNT_WIDTH-RW){1'b0}}, rows_sel};
  assign cols_ext  = {{(CNT_WIDTH-CW){1'b0}}, cols_sel};
  assign skew_len  = rows_ext + cols_ext - CNT_ONE;
  assign drain_len = (rows_ext < N_EXT) ? (N_EXT - rows_ext - CNT_ONE) : '0;
  assign store_len = rows_ext + CNT_ONE;

  // Next state, counter and next-cycle control values. The counter holds the
  // cycles left in the current phase; a phase ends on the cycle it reads 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    reject    = 1'b0;
    busy_nxt  = 1'b0;
    flow_nxt  = 1'b0;
    ag_nxt    = 1'b0;
    done_nxt  = 1'b0;
    op_nxt    = OP_IDLE;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_legal) begin
            accept = 1'b1;
            if (bus.cfg_k != '0) begin
              state_nxt = S_FLOW;
              cnt_nxt   = bus.cfg_k;
            end else begin
              state_nxt = S_SKEW;
              cnt_nxt   = skew_len;
            end
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_FLOW: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_SKEW;
          cnt_nxt   = skew_len;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_SKEW: begin
        if (cnt == CNT_ONE) begin
          if (drain_len != '0) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = drain_len;
          end else begin
            state_nxt = S_STORE;
            cnt_nxt   = store_len;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_DRAIN: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_STORE;
          cnt_nxt   = store_len;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_STORE: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Controls are decoded from the state being entered so they can be
    // registered and still line up with that state's cycles.
    busy_nxt = (state_nxt != S_IDLE);
    flow_nxt = (state_nxt == S_FLOW);
    ag_nxt   = (state_nxt == S_STORE);
    done_nxt = (state_nxt == S_DONE);
    unique case (state_nxt)
      S_FLOW, S_SKEW:   op_nxt = OP_FLOW;
      S_DRAIN, S_STORE: op_nxt = OP_DRAIN;
      default:          op_nxt = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      flow_q   <= 1'b0;
      ag_q     <= 1'b0;
      op_q     <= OP_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      a_base_q <= '0;
      w_base_q <= '0;
      o_base_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      err_q  <= reject;
      flow_q <= flow_nxt;
      ag_q   <= ag_nxt;
      op_q   <= op_nxt;
      // Latched config only moves on acceptance, which can only happen in IDLE.
      if (accept) begin
        rows_q   <= bus.cfg_num_rows;
        cols_q   <= bus.cfg_num_cols;
        a_base_q <= bus.cfg_a_base;
        w_base_q <= bus.cfg_w_base;
        o_base_q <= bus.cfg_o_base;
      end
    end
  end

  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.err                 = err_q;
  assign bus.mode                = busy_q;
  assign bus.a_buf_on            = flow_q;
  assign bus.w_buf_on            = flow_q;
  assign bus.operation_signal_in = op_q;
  assign bus.o_ag_o_on           = ag_q;
  assign bus.a_num_rows          = rows_q;
  assign bus.w_num_cols          = cols_q;
  assign bus.a_base_addr         = a_base_q;
  assign bus.w_base_addr         = w_base_q;
  assign bus.o_base_addr         = o_base_q;

endmodule

// File: tb/tb_os_tile_sequencer.sv
// Bench for os_tile_sequencer: directed tiles with literal timing plus random
// start/cfg traffic, all outputs compared every cycle against a phase-window model.
module tb_os_tile_sequencer;
  localparam int N   = 16;
  localparam int M   = 16;
  localparam int AW  = 10;
  localparam int KW  = 32;
  localparam int RW  = $clog2(N) + 1;
  localparam int CLW = $clog2(M) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  os_tile_sequencer_if #(.ARRAY_N(N), .ARRAY_M(M), .ADDR_WIDTH(AW), .CNT_WIDTH(KW)) bus ();

  os_tile_sequencer #(.ARRAY_N(N), .ARRAY_M(M), .ADDR_WIDTH(AW), .CNT_WIDTH(KW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          busy, done, err, mode, a_buf_on, w_buf_on;
    logic [2:0]    op;
    logic          o_ag;
    logic [AW-1:0] a_base, w_base, o_base;
    logic [RW-1:0] rows;
    logic [CLW-1:0] cols;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy = bus.busy; o.done = bus.done; o.err = bus.err; o.mode = bus.mode;
    o.a_buf_on = bus.a_buf_on; o.w_buf_on = bus.w_buf_on;
    o.op = bus.operation_signal_in; o.o_ag = bus.o_ag_o_on;
    o.a_base = bus.a_base_addr; o.w_base = bus.w_base_addr; o.o_base = bus.o_base_addr;
    o.rows = bus.a_num_rows; o.cols = bus.w_num_cols;
    return o;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // ---------------- reference model ----------------
  // A run accepted at posedge s occupies cycles 1..T, cycle c being the value
  // present after posedge s+c-1. Phases are plain consecutive windows.
  longint pcount = 0;
  bit     m_active = 0;
  longint m_s, m_k, m_r, m_c, m_d, m_t;
  longint m_err_p = -1;
  logic [AW-1:0]  m_a = '0, m_w = '0, m_o = '0;
  logic [RW-1:0]  m_rows = '0;
  logic [CLW-1:0] m_cols = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_err_p = -1;
      m_a = '0; m_w = '0; m_o = '0; m_rows = '0; m_cols = '0;
    end else begin
      pcount++;
      if (bus.start && (!m_active || pcount >= m_s + m_t + 1)) begin
        if (bus.cfg_num_rows >= 1 && int'(bus.cfg_num_rows) <= N &&
            bus.cfg_num_cols >= 1 && int'(bus.cfg_num_cols) <= M) begin
          m_active = 1;
          m_s = pcount;
          m_k = longint'(bus.cfg_k);
          m_r = longint'(bus.cfg_num_rows);
          m_c = longint'(bus.cfg_num_cols);
          m_d = (m_r < N) ? (N - m_r - 1) : 0;
          m_t = 1 + m_k + (m_r + m_c - 1) + m_d + (m_r + 1);
          m_a = bus.cfg_a_base; m_w = bus.cfg_w_base; m_o = bus.cfg_o_base;
          m_rows = bus.cfg_num_rows; m_cols = bus.cfg_num_cols;
        end else begin
          m_err_p = pcount;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    obs_t   e, a;
    longint c, f_end, s_end, d_end, st_end;
    e = '0;
    e.a_base = m_a; e.w_base = m_w; e.o_base = m_o; e.rows = m_rows; e.cols = m_cols;
    if (m_err_p == pcount) e.err = 1'b1;
    if (m_active) begin
      c      = pcount - m_s + 1;
      f_end  = m_k;
      s_end  = f_end + m_r + m_c - 1;
      d_end  = s_end + m_d;
      st_end = d_end + m_r + 1;
      if (c >= 1 && c <= m_t) begin
        e.busy = 1'b1; e.mode = 1'b1;
        if (c <= f_end) begin
          e.a_buf_on = 1'b1; e.w_buf_on = 1'b1; e.op = 3'b100;
        end else if (c <= s_end) begin
          e.op = 3'b100;
        end else if (c <= d_end) begin
          e.op = 3'b110;
        end else if (c <= st_end) begin
          e.op = 3'b110; e.o_ag = 1'b1;
        end else begin
          e.done = 1'b1;
        end
      end
    end
    a = sample();
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL outputs at edge %0d: got %h expected %h", pcount, a, e);
  end

  // ---------------- stimulus ----------------
  logic [AW-1:0] ba = 10'h012, bw = 10'h034, bo = 10'h056;

  task automatic drive_start(input longint k, input int r, input int c);
    bus.start        = 1'b1;
    bus.cfg_k        = KW'(k);
    bus.cfg_num_rows = RW'(r);
    bus.cfg_num_cols = CLW'(c);
    bus.cfg_a_base   = ba;
    bus.cfg_w_base   = bw;
    bus.cfg_o_base   = bo;
  endtask

  // Runs one tile from IDLE and checks first-op110 cycle, first-store cycle
  // and done cycle against hand-computed numbers.
  task automatic run_tile(input string nm, input longint k, input int r, input int c,
                          input int t_done, input int t_110, input int t_st);
    int got_done = -1;
    int got_110  = -1;
    int got_st   = -1;
    @(negedge clk);
    drive_start(k, r, c);
    @(negedge clk);
    bus.start = 1'b0;
    for (int cy = 1; cy <= 300; cy++) begin
      if (got_110 < 0 && bus.operation_signal_in == 3'b110) got_110 = cy;
      if (got_st < 0 && bus.o_ag_o_on) got_st = cy;
      if (bus.done) begin
        got_done = cy;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_done_cycle"}, got_done, t_done);
    check({nm, "_op110_cycle"}, got_110, t_110);
    check({nm, "_store_cycle"}, got_st, t_st);
    check({nm, "_model_T"}, m_t, t_done);
    @(negedge clk);
  endtask

  task automatic illegal(input string nm, input int r, input int c);
    @(negedge clk);
    drive_start(3, r, c);
    bus.cfg_a_base = 10'h3ff; bus.cfg_w_base = 10'h3ff; bus.cfg_o_base = 10'h3ff;
    @(negedge clk);
    bus.start = 1'b0;
    check({nm, "_err_cycle1"}, bus.err, 1);
    check({nm, "_busy"}, bus.busy, 0);
    @(negedge clk);
    check({nm, "_err_cycle2"}, bus.err, 0);
    check({nm, "_a_base_kept"}, bus.a_base_addr, 10'h012);
    check({nm, "_rows_kept"}, bus.a_num_rows, 6);
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_k = '0; bus.cfg_num_rows = '0; bus.cfg_num_cols = '0;
    bus.cfg_a_base = '0; bus.cfg_w_base = '0; bus.cfg_o_base = '0;

    repeat (3) @(negedge clk);
    check("reset_state", longint'(sample()), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_tile("full",    30, 16, 16, 79, 62, 62);
    run_tile("partial",  4,  6,  6, 32, 16, 25);
    illegal("rows0", 0, 6);
    illegal("cols17", 6, 17);
    run_tile("k0",       0,  1,  1, 18,  2, 16);
    check("k0_drain_len", m_d, 14);

    // start with new cfg mid-run, then asynchronous reset mid-run
    @(negedge clk);
    drive_start(4, 6, 6);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    drive_start(1, 2, 3);
    bus.cfg_a_base = 10'h3ff;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start_rows", bus.a_num_rows, 6);
    check("busy_start_base", bus.a_base_addr, 10'h012);
    repeat (9) @(negedge clk);
    check("pre_reset_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", longint'(sample()), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_tile("after_reset", 4, 6, 6, 32, 16, 25);

    // back-to-back: start held high across the end of a run (K=2,R=C=2 -> T=22)
    begin
      bit seen_done = 0;
      bit rerun     = 0;
      int low_cnt   = 0;
      int done_cy   = -1;
      int rerun_cy  = -1;
      @(negedge clk);
      drive_start(2, 2, 2);
      for (int cy = 1; cy <= 200 && !rerun; cy++) begin
        @(negedge clk);
        if (bus.done) begin
          seen_done = 1; done_cy = cy;
        end else if (seen_done && !bus.busy) begin
          low_cnt++;
        end else if (seen_done && bus.busy) begin
          rerun = 1; rerun_cy = cy; bus.start = 1'b0;
        end
      end
      bus.start = 1'b0;
      check("b2b_first_done", done_cy, 22);
      check("b2b_rerun", rerun, 1);
      check("b2b_busy_gap", low_cnt, 1);
      check("b2b_rerun_offset", rerun_cy - done_cy, 2);
      for (int cy = 0; cy < 100 && bus.busy; cy++) @(negedge clk);
      check("b2b_second_ends", bus.busy, 0);
    end

    // random traffic, one reset pulse in the middle
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (i == 250) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      bus.start        = ($urandom_range(0, 3) == 0);
      bus.cfg_k        = KW'($urandom_range(0, 10));
      bus.cfg_num_rows = RW'($urandom_range(0, 17));
      bus.cfg_num_cols = CLW'($urandom_range(0, 17));
      bus.cfg_a_base   = AW'($urandom);
      bus.cfg_w_base   = AW'($urandom);
      bus.cfg_o_base   = AW'($urandom);
    end
    bus.start = 1'b0;
    repeat (90) @(negedge clk);
    check("final_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/os_tile_sequencer.md
# os_tile_sequencer

Control FSM that runs one output-stationary (OS) tile on `systolic_system`. On a `start` handshake it latches the tile configuration, then drives the buffer-enable, operation-code and output-aggregation controls through four phases: FLOW, SKEW, DRAIN and STORE. It replaces hand-timed testbench stimulus with a single reusable sequencer that sits between the host/command decoder and `systolic_system`.

## Interface
Parameters:
- `ARRAY_N`, 16, systolic rows; bounds `cfg_num_rows`.
- `ARRAY_M`, 16, systolic columns; bounds `cfg_num_cols`.
- `ADDR_WIDTH`, 10, buffer address width.
- `CNT_WIDTH`, 32, width of `cfg_k` and the phase counter.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a tile run; sampled only in IDLE.
- `cfg_k`  in  CNT_WIDTH  reduction depth K.
- `cfg_num_rows`  in  $clog2(ARRAY_N)+1  active rows R.
- `cfg_num_cols`  in  $clog2(ARRAY_M)+1  active columns C.
- `cfg_a_base`, `cfg_w_base`, `cfg_o_base`  in  ADDR_WIDTH each  buffer base addresses.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse on tile completion.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `mode`  out  1  1 (OS) while busy, 0 otherwise.
- `a_buf_on`, `w_buf_on`  out  1 each  buffer streaming enables.
- `a_base_addr`, `w_base_addr`, `o_base_addr`  out  ADDR_WIDTH each  latched bases.
- `a_num_rows`, `w_num_cols`  out  as cfg  latched R and C.
- `operation_signal_in`  out  3  array op code: 3'b000 idle, 3'b100 OS flow, 3'b110 OS drain.
- `o_ag_o_on`  out  1  output-buffer aggregation/store enable.

## Operation
- States: IDLE, FLOW, SKEW, DRAIN, STORE, DONE. A single down-counter is loaded with the phase length on entry to each phase. The phase exits when the counter reaches 1; a phase of length 0 is skipped.
- IDLE:
  - `start` with R in 1..ARRAY_N and C in 1..ARRAY_M latches all cfg inputs and goes to FLOW, or to SKEW if K=0.
  - `start` with R or C out of range pulses `err` and stays in IDLE.
- FLOW: length K. `a_buf_on`=`w_buf_on`=1, op=3'b100.
- SKEW: length R+C-1. Buffers off, op=3'b100.
- DRAIN: length D = ARRAY_N-R-1 if R<ARRAY_N, otherwise D=0 and the phase is skipped. op=3'b110.
- STORE: length R+1. op=3'b110, `o_ag_o_on`=1.
- DONE: one cycle, `done`=1, op=3'b000, then IDLE.
- Arithmetic:
  - R+C-1 and D are computed at CNT_WIDTH with zero-extended operands.
  - DRAIN length never goes negative.
  - K is unsigned; K=2^CNT_WIDTH-1 must run to completion without overflow.
- Latched config and base outputs hold their values from `start` acceptance until the next acceptance. Base outputs are never changed while busy.
- `start` while busy is ignored: no `err`, and no effect on the current run.

## Timing
- All outputs are registered. Reset values: every output 0, including `operation_signal_in`=3'b000 and the latched bases, R and C.
- Cycle numbering: cycle 0 is the edge that samples `start`. Phase outputs first appear in cycle 1.
- Phase cycle ranges:
  - FLOW: cycles 1..K.
  - SKEW: next R+C-1 cycles.
  - DRAIN: next D cycles.
  - STORE: next R+1 cycles.
- `done` is high in cycle T = 1+K+(R+C-1)+D+(R+1) and `busy` drops in cycle T+1. A new `start` can be accepted in cycle T+1, giving back-to-back runs a 1-cycle gap.
- `err` is high in cycle 1 only.
- Asserting `reset` at any point forces IDLE and all outputs to 0 immediately, without waiting for a clock edge. After deassertion, the first accepted `start` runs a full, clean tile.

## Test plan
- Full-size tile (ARRAY_N=16, K=30, R=C=16):
  - buffers on and op=100 in cycles 1–30.
  - op=100 with buffers off in cycles 31–61.
  - DRAIN skipped; op=110 and `o_ag_o_on`=1 in cycles 62–78.
  - `done` in cycle 79.
- Partial tile (K=4, R=C=6):
  - FLOW in cycles 1–4, SKEW in 5–15.
  - DRAIN (op=110, `o_ag_o_on`=0) in 16–24.
  - STORE in 25–31, `done` in 32.
- Illegal config (R=0, and separately C=17): `err` pulses in cycle 1, `busy` stays 0, and latched outputs are unchanged.
- Degenerate K (K=0, R=C=1):
  - FLOW skipped; SKEW in cycle 1.
  - DRAIN (14 cycles) in 2–15, STORE in 16–17, `done` in 18.
- Busy start and mid-run reset:
  - pulsing `start` with new cfg in cycle 10 of a run changes nothing.
  - asserting `reset` low in cycle 20 zeroes all outputs immediately.
  - after release, a K=4, R=C=6 run repeats the partial-tile timing exactly.
- Back-to-back runs: `start` held high continuously gives a second run accepted in cycle T+1, with `busy` low for exactly one cycle between runs.
